// File: rtl/dff_sync_rst.sv
`default_nettype none
// ============================================================================
//  Module   : dff_sync_rst
//  Purpose  : Single-bit rising-edge D flip-flop with synchronous active-low
//             reset and complementary registered outputs Q / Q_bar.
//  Revision : 1.0 - initial release
// ============================================================================
module dff_sync_rst #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic D,
  input  logic clk,
  input  logic rst,
  output logic Q,
  output logic Q_bar
);

  logic r_q;
  logic r_q_bar;

  // Both outputs are registered so Q_bar never lags Q by a gate delay.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q     <= RESET_VALUE;
      r_q_bar <= ~RESET_VALUE;
    end else begin
      r_q     <= D;
      r_q_bar <= ~D;
    end
  end

  assign Q     = r_q;
  assign Q_bar = r_q_bar;

endmodule
`default_nettype wire

// File: tb/tb_dff_sync_rst.sv
`default_nettype none
// Directed bench for dff_sync_rst: single bit, RESET_VALUE=1 variant,
// 8-bit parallel register and 8-bit serial-in shift register compositions.
module tb_dff_sync_rst;

  logic       clk;
  logic       rst;
  logic       d;
  logic       q, q_bar;
  logic       q1, q1_bar;
  logic [7:0] reg_d, reg_q, reg_qb;
  logic       s_in;
  logic [7:0] sh_q, sh_qb;
  logic       s_out;

  int vectors;
  int miscompares;

  dff_sync_rst #(.RESET_VALUE(1'b0)) u_dut0 (.D(d), .clk(clk), .rst(rst), .Q(q),  .Q_bar(q_bar));
  dff_sync_rst #(.RESET_VALUE(1'b1)) u_dut1 (.D(d), .clk(clk), .rst(rst), .Q(q1), .Q_bar(q1_bar));

  for (genvar k = 0; k < 8; k++) begin : g_reg
    dff_sync_rst u_bit (.D(reg_d[k]), .clk(clk), .rst(rst), .Q(reg_q[k]), .Q_bar(reg_qb[k]));
  end

  for (genvar k = 0; k < 8; k++) begin : g_sh
    if (k == 7) begin : g_msb
      dff_sync_rst u_bit (.D(s_in), .clk(clk), .rst(rst), .Q(sh_q[k]), .Q_bar(sh_qb[k]));
    end else begin : g_lsb
      dff_sync_rst u_bit (.D(sh_q[k+1]), .clk(clk), .rst(rst), .Q(sh_q[k]), .Q_bar(sh_qb[k]));
    end
  end
  assign s_out = sh_q[0];

  initial clk = 1'b0;
  always #101 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 50 ns after each falling edge.
  task automatic next_slot();
    @(negedge clk);
    #50;
  endtask

  initial begin
    logic       v;
    logic [7:0] exp_sh;
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b0;
    d     = 1'b1;
    reg_d = 8'h00;
    s_in  = 1'b0;

    // Reset with D=1 at the same edge: reset wins in both variants.
    next_slot();
    check1("rst_q",       q,      1'b0);
    check1("rst_qbar",    q_bar,  1'b1);
    check1("rst_q_rv1",   q1,     1'b1);
    check1("rst_qbar_rv1", q1_bar, 1'b0);
    check8("rst_reg",     reg_q,  8'h00);
    check8("rst_sh",      sh_q,   8'h00);

    for (int i = 0; i < 3; i++) begin
      d = ~d;
      next_slot();
      check1("rst_hold_q", q, 1'b0);
      check1("rst_hold_q_rv1", q1, 1'b1);
    end

    // Capture.
    rst = 1'b1;
    d   = 1'b1;
    next_slot();
    check1("cap1_q",    q,      1'b1);
    check1("cap1_qbar", q_bar,  1'b0);
    check1("cap1_q_rv1", q1,    1'b1);
    d = 1'b0;
    next_slot();
    check1("cap0_q",    q,      1'b0);
    check1("cap0_qbar", q_bar,  1'b1);
    check1("cap0_q_rv1", q1,    1'b0);
    d = 1'b1;
    #20;
    check1("between_edges_q", q, 1'b0);
    next_slot();
    check1("after_edge_q", q, 1'b1);

    // Parallel register.
    reg_d = 8'hA5;
    next_slot();
    check8("reg_a5", reg_q,  8'hA5);
    check8("reg_a5_bar", reg_qb, 8'h5A);
    reg_d = 8'h3C;
    next_slot();
    check8("reg_3c", reg_q, 8'h3C);

    // Shift register: sh_q has been shifting zeros since reset.
    check8("sh_pre", sh_q, 8'h00);
    s_in   = 1'b1;
    exp_sh = 8'h00;
    for (int i = 0; i < 8; i++) begin
      next_slot();
      exp_sh = {1'b1, exp_sh[7:1]};
      check8("sh_q", sh_q, exp_sh);
      check1("sh_out", s_out, (i == 7) ? 1'b1 : 1'b0);
    end
    check8("sh_full", sh_q, 8'hFF);

    // Random data.
    for (int i = 0; i < 50; i++) begin
      v = 1'($urandom_range(0, 1));
      d = v;
      next_slot();
      check1("rand_q",    q,     v);
      check1("rand_qbar", q_bar, ~v);
    end

    // Synchronous reset asserted and released mid-cycle.
    d = 1'b1;
    @(posedge clk);
    #1;
    check1("mid_pre_q", q, 1'b1);
    #50;
    rst = 1'b0;
    #1;
    check1("mid_rst_no_effect", q, 1'b1);
    check1("mid_rst_no_effect_bar", q_bar, 1'b0);
    @(posedge clk);
    #1;
    check1("mid_rst_q",    q,     1'b0);
    check1("mid_rst_qbar", q_bar, 1'b1);
    check1("mid_rst_q_rv1", q1,   1'b1);
    #50;
    rst = 1'b1;
    #1;
    check1("mid_rel_no_effect", q, 1'b0);
    @(posedge clk);
    #1;
    check1("mid_rel_load_q",    q,     1'b1);
    check1("mid_rel_load_qbar", q_bar, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dff_sync_rst.md
Name: dff_sync_rst

Overview:
- Single-bit, positive-edge D flip-flop with synchronous reset and complementary outputs Q and Q_bar.
- It is the storage primitive replicated per bit in the 8-bit parallel register and the 8-bit serial-in/parallel-out shift register.
- Those containers instantiate it positionally, so port order is fixed (see Ports).

Parameters:
- RESET_VALUE, 1'b0, value loaded into Q while reset is asserted. Q_bar takes the complement.

Ports:
- clk  input  1  clock; all state changes occur on its rising edge only.
- rst  input  1  reset; synchronous, active-low.
- D  input  1  data input, sampled at the rising edge of clk.
- Q  output  1  stored bit.
- Q_bar  output  1  complement of Q at all times.
- Positional instantiation order: (D, clk, rst, Q, Q_bar). Parent modules connect by position, so the declaration order must be exactly this.

Behaviour:
- Reset: rst is synchronous, active-low.
  - At a rising edge of clk with rst==0: Q <= RESET_VALUE and Q_bar <= ~RESET_VALUE.
  - Reset has priority over D.
  - Asserting or deasserting rst between clock edges has no effect on the outputs until the next rising edge.
- Normal operation: at a rising edge with rst==1, Q <= D and Q_bar <= ~D. Latency is 1 clock, with no combinational path from D to Q.
- Hold: between rising edges, Q and Q_bar keep their value regardless of D or rst activity. Falling edges do nothing.
- Complement invariant: Q_bar == ~Q at all times after the first clock edge, with no transient mismatch visible at cycle granularity.
- Power-up: before the first rising edge, Q is X. Benches must apply reset for at least one rising edge before checking values.
- Reset mid-operation: if rst goes low while Q==1, Q goes to RESET_VALUE at the next rising edge and stays there every edge while rst==0. The first rising edge with rst==1 loads D.
- X on D with rst==1 propagates X to Q and Q_bar. X on rst is not supported.
- Timing: D must be stable at least 1 ns before the rising edge. The bench changes D near the falling edge, about 50 ns after it with a 202 ns period.
- Composition contract:
  - 8-bit register: bit k uses D[k] -> Q[k], with all bits sharing clk and rst.
  - Shift register: IN[7]=sIn, IN[k]=Q[k+1], sOut=Q[0].
  - One shift per rising edge. A bit entered at sIn appears at sOut after 8 rising edges.

Test Plan:
- Reset: rst=0, D=1, one rising edge -> Q=0, Q_bar=1. Hold rst=0 for 3 edges while toggling D -> Q stays 0.
- Capture: rst=1. Apply D=1, rising edge -> Q=1, Q_bar=0. Then D=0, rising edge -> Q=0, Q_bar=1. Changing D between edges does not change Q.
- Random data: 50 cycles with random D changed 50 ns after each falling edge. At the next falling edge +50 ns, Q equals the D applied before the preceding rising edge, and Q_bar == ~Q at every check.
- Sync reset mid-stream: Q=1, drive rst=0 midway between edges -> Q still 1 until the next rising edge, then 0. Release rst mid-cycle -> next edge loads D.
- Register and shift composition:
  - 8 instances as a register with rst=1: D=8'hA5 -> Q=8'hA5 one edge later.
  - 8 instances as a shift register: after reset, sIn=1 held for 8 edges -> Q goes 8'h80, 8'hC0, ... 8'hFF, and sOut=1 on the 8th edge.
- Priority: rst=0 and D=1 at the same edge -> Q=0 (RESET_VALUE). Repeat with RESET_VALUE=1 -> Q=1, Q_bar=0.
